// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] INITIAL_PC = 32'h0040_0000;
    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake bundle between fetch, instruction memory, decode and the execute redirect path.
interface fetch_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [31:0]      imem_rsp_data;
    logic             inst_valid;
    logic             inst_ready;
    logic [31:0]      inst;
    logic [WIDTH-1:0] inst_pc;
    logic [WIDTH-1:0] inst_pc_plus_4;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;

    // Fetch-stage side.
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_pc_plus_4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid,
        redirect_pc
    );

    // Memory / decode / execute side.
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_pc_plus_4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid,
        redirect_pc
    );

endinterface

// File: rtl/fetch_stage_adder.sv
// Plain modular adder; the sum wraps at 2^WIDTH.
module fetch_stage_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = operand_a_i + operand_b_i;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and holds the result for
// decode. Redirects win over everything and mark any in-flight response as stale.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(INITIAL_PC)
) (
    input logic          clock,
    input logic          reset_n,
    fetch_stage_if.master bus
);

    localparam logic [WIDTH-1:0] AlignMask = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] ResetPcAligned = RESET_PC & AlignMask;

    fetch_state_t     state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] req_pc_q;
    logic             discard_q;
    logic             req_valid_q;
    logic             inst_valid_q;
    logic [31:0]      inst_q;
    logic [WIDTH-1:0] inst_pc_q;
    logic [WIDTH-1:0] inst_pc_plus_4_q;

    logic [WIDTH-1:0] req_pc_plus_4;
    logic [WIDTH-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = bus.redirect_pc & AlignMask;

    fetch_stage_adder #(
        .WIDTH (WIDTH)
    ) u_pc_adder (
        .operand_a_i (req_pc_q),
        .operand_b_i (WIDTH'(INST_BYTES)),
        .sum_o       (req_pc_plus_4)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            pc_q             <= ResetPcAligned;
            req_pc_q         <= ResetPcAligned;
            discard_q        <= 1'b0;
            req_valid_q      <= 1'b0;
            inst_valid_q     <= 1'b0;
            inst_q           <= '0;
            inst_pc_q        <= '0;
            inst_pc_plus_4_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q     <= REQ;
                    req_valid_q <= 1'b1;
                    if (bus.redirect_valid) pc_q <= redirect_pc_aligned;
                end
                REQ: begin
                    // An accepted request is already in flight, so a same-cycle redirect
                    // must discard whatever comes back for it.
                    if (bus.imem_req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                        req_pc_q    <= pc_q;
                        discard_q   <= bus.redirect_valid;
                    end
                    if (bus.redirect_valid) pc_q <= redirect_pc_aligned;
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        discard_q <= 1'b0;
                        if (bus.redirect_valid || discard_q) begin
                            state_q     <= REQ;
                            req_valid_q <= 1'b1;
                            if (bus.redirect_valid) pc_q <= redirect_pc_aligned;
                        end else begin
                            state_q          <= HOLD;
                            inst_valid_q     <= 1'b1;
                            inst_q           <= bus.imem_rsp_data;
                            inst_pc_q        <= req_pc_q;
                            inst_pc_plus_4_q <= req_pc_plus_4;
                            pc_q             <= req_pc_plus_4;
                        end
                    end else if (bus.redirect_valid) begin
                        discard_q <= 1'b1;
                        pc_q      <= redirect_pc_aligned;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid || bus.inst_ready) begin
                        state_q      <= REQ;
                        req_valid_q  <= 1'b1;
                        inst_valid_q <= 1'b0;
                        if (bus.redirect_valid) pc_q <= redirect_pc_aligned;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_pc_plus_4 = inst_pc_plus_4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage, plus a second instance at the top of the address space.
module tb_fetch_stage;

    logic clock;
    logic reset_n;

    fetch_stage_if #(.WIDTH(32)) bus ();
    fetch_stage_if #(.WIDTH(32)) bus2 ();

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0040_0000)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory that answers one cycle after every accepted request.
    always @(posedge clock) begin
        bus2.imem_rsp_valid <= bus2.imem_req_valid & bus2.imem_req_ready;
    end

    typedef struct {
        logic        rdv;
        logic [31:0] rdpc;
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ir;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic [31:0] e_ipc4;
    } vec_t;

    vec_t vq[$];
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic rqv, input logic [31:0] addr,
                                 input logic iv, input logic [31:0] ins,
                                 input logic [31:0] ipc, input logic [31:0] ipc4);
        check({tag, ".req_valid"}, 32'(bus.imem_req_valid), 32'(rqv));
        check({tag, ".req_addr"}, bus.imem_req_addr, addr);
        check({tag, ".inst_valid"}, 32'(bus.inst_valid), 32'(iv));
        check({tag, ".inst"}, bus.inst, ins);
        check({tag, ".inst_pc"}, bus.inst_pc, ipc);
        check({tag, ".inst_pc_plus_4"}, bus.inst_pc_plus_4, ipc4);
    endtask

    task automatic drive_idle();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
    endtask

    initial begin
        bit found;
        checks = 0;
        errors = 0;

        //          rdv rdpc          rqr rsv rsd           ir  rqv addr          iv inst          ipc           ipc4
        vq.push_back('{0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h0040_0000, 0, 32'h0,        32'h0,        32'h0});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0000, 0, 32'h0,        32'h0,        32'h0});
        vq.push_back('{0, 32'h0,        0, 1, 32'h0000_0013,1,  0, 32'h0040_0004, 1, 32'h13,       32'h0040_0000,32'h0040_0004});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        1,  1, 32'h0040_0004, 0, 32'h13,       32'h0040_0000,32'h0040_0004});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0004, 0, 32'h13,       32'h0040_0000,32'h0040_0004});
        vq.push_back('{0, 32'h0,        0, 1, 32'h0050_0093,0,  0, 32'h0040_0008, 1, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        // Decode stalls five cycles, with a stray response that must be ignored.
        vq.push_back('{0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0040_0008, 1, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        0, 1, 32'hFFFF_FFFF,0,  0, 32'h0040_0008, 1, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0040_0008, 1, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0008, 1, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0040_0008, 1, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0040_0008, 0, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        // Redirect while waiting; the late response is stale.
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0008, 0, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{1, 32'h0040_0103,0, 0, 32'h0,        0,  0, 32'h0040_0100, 0, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0040_0100, 0, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        0, 1, 32'hDEAD_BEEF,0,  1, 32'h0040_0100, 0, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0100, 0, 32'h0050_0093,32'h0040_0004,32'h0040_0008});
        vq.push_back('{0, 32'h0,        0, 1, 32'h1111_1111,0,  0, 32'h0040_0104, 1, 32'h1111_1111,32'h0040_0100,32'h0040_0104});
        vq.push_back('{0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h0040_0104, 0, 32'h1111_1111,32'h0040_0100,32'h0040_0104});
        // Redirect in the same cycle the request is accepted.
        vq.push_back('{1, 32'h0040_0200,1, 0, 32'h0,        0,  0, 32'h0040_0200, 0, 32'h1111_1111,32'h0040_0100,32'h0040_0104});
        vq.push_back('{0, 32'h0,        0, 1, 32'h2222_2222,0,  1, 32'h0040_0200, 0, 32'h1111_1111,32'h0040_0100,32'h0040_0104});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0200, 0, 32'h1111_1111,32'h0040_0100,32'h0040_0104});
        vq.push_back('{0, 32'h0,        0, 1, 32'h3333_3333,0,  0, 32'h0040_0204, 1, 32'h3333_3333,32'h0040_0200,32'h0040_0204});
        // Redirect in HOLD without consume, then in REQ without ready.
        vq.push_back('{1, 32'h0040_0300,0, 0, 32'h0,        0,  1, 32'h0040_0300, 0, 32'h3333_3333,32'h0040_0200,32'h0040_0204});
        vq.push_back('{1, 32'h0040_0404,0, 0, 32'h0,        0,  1, 32'h0040_0404, 0, 32'h3333_3333,32'h0040_0200,32'h0040_0204});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0404, 0, 32'h3333_3333,32'h0040_0200,32'h0040_0204});
        // Redirect coinciding with the response: dropped, and no stale flag left behind.
        vq.push_back('{1, 32'h0040_0500,0, 1, 32'h4444_4444,0,  1, 32'h0040_0500, 0, 32'h3333_3333,32'h0040_0200,32'h0040_0204});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0500, 0, 32'h3333_3333,32'h0040_0200,32'h0040_0204});
        vq.push_back('{0, 32'h0,        0, 1, 32'h5555_5555,0,  0, 32'h0040_0504, 1, 32'h5555_5555,32'h0040_0500,32'h0040_0504});
        vq.push_back('{1, 32'h0040_0600,0, 0, 32'h0,        1,  1, 32'h0040_0600, 0, 32'h5555_5555,32'h0040_0500,32'h0040_0504});
        vq.push_back('{0, 32'h0,        1, 0, 32'h0,        0,  0, 32'h0040_0600, 0, 32'h5555_5555,32'h0040_0500,32'h0040_0504});

        drive_idle();
        bus2.imem_req_ready = 1'b1;
        bus2.inst_ready     = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.imem_rsp_data  = 32'h0000_0013;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        tick();
        tick();
        check_outputs("reset", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0, 32'h0);
        check("reset.wrap_addr", bus2.imem_req_addr, 32'hFFFF_FFFC);
        reset_n = 1'b1;

        foreach (vq[i]) begin
            bus.redirect_valid = vq[i].rdv;
            bus.redirect_pc    = vq[i].rdpc;
            bus.imem_req_ready = vq[i].rqr;
            bus.imem_rsp_valid = vq[i].rsv;
            bus.imem_rsp_data  = vq[i].rsd;
            bus.inst_ready     = vq[i].ir;
            tick();
            check_outputs($sformatf("vec%0d", i), vq[i].e_rqv, vq[i].e_addr, vq[i].e_iv,
                          vq[i].e_inst, vq[i].e_ipc, vq[i].e_ipc4);
        end

        // Reset mid-WAIT takes effect without a clock edge.
        drive_idle();
        #3 reset_n = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h0, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h6666_6666;
        tick();
        reset_n = 1'b1;
        tick();
        check_outputs("late_rsp", 1'b1, 32'h0040_0000, 1'b0, 32'h0, 32'h0, 32'h0);
        bus.imem_rsp_valid = 1'b0;
        tick();
        check_outputs("post_reset", 1'b1, 32'h0040_0000, 1'b0, 32'h0, 32'h0, 32'h0);

        // Second instance: PC+4 wraps past the top of the address space.
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            found = bus2.inst_valid;
        end
        check("wrap.inst_seen", 32'(found), 32'd1);
        check("wrap.inst_pc", bus2.inst_pc, 32'hFFFF_FFFC);
        check("wrap.inst_pc_plus_4", bus2.inst_pc_plus_4, 32'h0000_0000);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            found = bus2.imem_req_valid;
        end
        check("wrap.req_seen", 32'(found), 32'd1);
        check("wrap.req_addr", bus2.imem_req_addr, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
